fifo_rd_stream: RTL and testbench

- Read-side consumer for the dual-clock FIFO. Runs in the read clock domain.
- Drives the FIFO pop strobe from the empty flag.
- Captures read data into a 2-entry output buffer and presents it as a valid/ready stream to downstream logic.
- No combinational path from downstream ready to the FIFO pop. Also counts the words it delivers.

---
 rtl/fifo_rd_stream.sv | 99 +++++++++
 tb/tb_fifo_rd_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Read-side consumer for a dual-clock FIFO. Pops FWFT words
//                into a 2-entry skid buffer and presents them as a
//                valid/ready stream; counts delivered words.
//  Revision    : 1.0
// ============================================================================
module fifo_rd_stream #(
    parameter int DSIZE = 16,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rd_en,
    input  logic             rempty,
    input  logic             rempty_almost,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             rd_low,
    output logic [CNTW-1:0]  xfer_cnt
);

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    logic [1:0]       r_occ;
    logic [DSIZE-1:0] r_e0;
    logic [DSIZE-1:0] r_e1;
    logic [CNTW-1:0]  r_xfer_cnt;
    logic             r_rd_low;
    logic             w_push;
    logic             w_pop;

    // Pop decision uses only registered occupancy and the FIFO flag, so
    // downstream ready never reaches the FIFO pointer logic combinationally.
    assign rinc     = rd_en & ~rempty & (r_occ < c_OCC_FULL) & ~rrst;
    assign w_push   = rinc;
    assign m_valid  = (r_occ != c_OCC_EMPTY);
    assign w_pop    = m_valid & m_ready;
    assign m_data   = r_e0;
    assign xfer_cnt = r_xfer_cnt;
    assign rd_low   = r_rd_low;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_occ <= c_OCC_EMPTY;
            r_e0  <= '0;
            r_e1  <= '0;
        end else begin
            case (r_occ)
                c_OCC_EMPTY: begin
                    if (w_push) begin
                        r_e0  <= rdata;
                        r_occ <= c_OCC_ONE;
                    end
                end
                c_OCC_ONE: begin
                    if (w_push && w_pop) begin
                        r_e0 <= rdata;
                    end else if (w_push) begin
                        r_e1  <= rdata;
                        r_occ <= c_OCC_FULL;
                    end else if (w_pop) begin
                        r_occ <= c_OCC_EMPTY;
                    end
                end
                c_OCC_FULL: begin
                    // No push possible here; e0/e1 hold while stalled.
                    if (w_pop) begin
                        r_e0  <= r_e1;
                        r_occ <= c_OCC_ONE;
                    end
                end
                default: begin
                    r_occ <= c_OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_xfer_cnt <= '0;
            r_rd_low   <= 1'b0;
        end else begin
            r_rd_low <= rempty_almost;
            if (w_pop) begin
                r_xfer_cnt <= r_xfer_cnt + CNTW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_stream
//  Description : Directed self-checking bench for fifo_rd_stream with a
//                behavioural FWFT FIFO feeding it.
//  Revision    : 1.0
// ============================================================================
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        rempty;
    logic        rempty_almost;
    logic        m_ready;
    logic [15:0] rdata;

    logic        rinc,  m_valid,  rd_low;
    logic [15:0] m_data, xfer_cnt;
    logic        rinc4, m_valid4, rd_low4;
    logic [15:0] m_data4;
    logic [3:0]  xfer_cnt4;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DSIZE(16), .CNTW(16)) dut (
        .rclk(clk), .rrst(rst), .rd_en(rd_en), .rempty(rempty),
        .rempty_almost(rempty_almost), .rdata(rdata), .rinc(rinc),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .rd_low(rd_low), .xfer_cnt(xfer_cnt)
    );

    fifo_rd_stream #(.DSIZE(16), .CNTW(4)) dut4 (
        .rclk(clk), .rrst(rst), .rd_en(rd_en), .rempty(rempty),
        .rempty_almost(rempty_almost), .rdata(rdata), .rinc(rinc4),
        .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .rd_low(rd_low4), .xfer_cnt(xfer_cnt4)
    );

    // Behavioural first-word-fall-through FIFO; read side resets with the DUT.
    logic [15:0] mem [0:255];
    int wptr = 0;
    int rptr = 0;
    assign rempty = (wptr == rptr);
    assign rdata  = mem[rptr[7:0]];

    always @(posedge clk or posedge rst) begin
        if (rst)       rptr <= wptr;
        else if (rinc) rptr <= rptr + 1;
    end

    // Stream monitor: records handshakes, counts pops, watches stall stability.
    logic [15:0] got [$];
    int          rinc_cnt   = 0;
    int          stall_err  = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] stall_data = 16'h0;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (m_data != stall_data)) stall_err++;
            if (rinc) rinc_cnt++;
            if (m_valid && m_ready) got.push_back(m_data);
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] v);
        mem[wptr[7:0]] = v;
        wptr++;
    endtask

    task automatic check_got(input string tag, input int base, input logic [15:0] first, input int n);
        logic [31:0] v;
        check_eq({tag, "_count"}, got.size() - base, n);
        for (int i = 0; i < n; i++) begin
            v = (base + i < got.size()) ? {16'h0, got[base + i]} : 32'hDEAD_BEEF;
            check_eq({tag, "_word"}, v, first + 16'(i));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int base;
    int rc0;
    int se0;

    initial begin
        rst = 1'b1; rd_en = 1'b0; rempty_almost = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid",  m_valid,  0);
        check_eq("rst_data",   m_data,   0);
        check_eq("rst_cnt",    xfer_cnt, 0);
        check_eq("rst_rinc",   rinc,     0);
        check_eq("rst_rdlow",  rd_low,   0);
        check_eq("rst_valid4", m_valid4, 0);
        check_eq("rst_data4",  m_data4,  0);
        check_eq("rst_cnt4",   xfer_cnt4, 0);
        check_eq("rst_rinc4",  rinc4,    0);
        check_eq("rst_rdlow4", rd_low4,  0);
        rst = 1'b0;

        // Test 1: full-rate streaming of 0x0001..0x0008
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        m_ready = 1'b1;
        base = got.size(); rc0 = rinc_cnt;
        rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq("t1_data",  m_data,  i);
            check_eq("t1_valid", m_valid, 1);
        end
        tick();
        check_eq("t1_idle", m_valid, 0);
        check_eq("t1_cnt",  xfer_cnt, 8);
        check_eq("t1_rinc", rinc_cnt - rc0, 8);
        check_got("t1_got", base, 16'h0001, 8);

        // Test 2: backpressure fills the buffer, then drains in order
        m_ready = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 5; i++) push_word(16'h00A0 + 16'(i));
        base = got.size(); rc0 = rinc_cnt;
        rd_en = 1'b1;
        repeat (5) tick();
        check_eq("t2_rinc_n", rinc_cnt - rc0, 2);
        check_eq("t2_rinc",   rinc,    0);
        check_eq("t2_valid",  m_valid, 1);
        check_eq("t2_hold",   m_data,  16'h00A0);
        m_ready = 1'b1;
        repeat (8) tick();
        check_got("t2_got", base, 16'h00A0, 5);
        check_eq("t2_cnt", xfer_cnt, 13);

        // Test 3: alternating ready with 6 words queued
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(16'h00B0 + 16'(i));
        base = got.size(); se0 = stall_err;
        for (int i = 0; i < 20; i++) begin
            m_ready = (i % 2 == 0);
            tick();
        end
        m_ready = 1'b1;
        repeat (3) tick();
        check_got("t3_got", base, 16'h00B0, 6);
        check_eq("t3_stall", stall_err - se0, 0);
        check_eq("t3_cnt", xfer_cnt, 19);

        // Test 4: rd_en gating and a single-cycle enable
        rd_en = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) push_word(16'h00C0 + 16'(i));
        base = got.size(); rc0 = rinc_cnt;
        repeat (3) tick();
        check_eq("t4_norinc", rinc_cnt - rc0, 0);
        check_eq("t4_rinc",   rinc,    0);
        check_eq("t4_valid0", m_valid, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_eq("t4_valid1", m_valid, 1);
        check_eq("t4_data",   m_data,  16'h00C0);
        repeat (3) tick();
        check_got("t4_got", base, 16'h00C0, 1);
        check_eq("t4_rinc_n", rinc_cnt - rc0, 1);
        check_eq("t4_cnt",    xfer_cnt, 20);
        check_eq("t4_valid2", m_valid, 0);

        // Test 5: asynchronous reset while the buffer is full
        m_ready = 1'b0; rd_en = 1'b1;
        repeat (3) tick();
        check_eq("t5_valid", m_valid, 1);
        check_eq("t5_data",  m_data,  16'h00C1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t5_rvalid", m_valid,   0);
        check_eq("t5_rdata",  m_data,    0);
        check_eq("t5_rcnt",   xfer_cnt,  0);
        check_eq("t5_rrinc",  rinc,      0);
        check_eq("t5_rdata4", m_data4,   0);
        check_eq("t5_rcnt4",  xfer_cnt4, 0);
        tick();
        rst = 1'b0;
        base = got.size();
        push_word(16'h5555);
        m_ready = 1'b1;
        repeat (4) tick();
        check_got("t5_got", base, 16'h5555, 1);
        check_eq("t5_cnt", xfer_cnt, 1);

        // Test 6: 4-bit counter wrap and rd_low latency
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check_eq("t6_cnt0",  xfer_cnt,  0);
        check_eq("t6_cnt40", xfer_cnt4, 0);
        for (int i = 0; i < 17; i++) push_word(16'h0D00 + 16'(i));
        for (int k = 1; k <= 18; k++) begin
            if (k <= 4) begin
                rempty_almost = k[0];
                check_eq("t6_rdlow_old", rd_low, !k[0]);
            end
            tick();
            if (k <= 4) check_eq("t6_rdlow_new", rd_low, k[0]);
            if (k == 16) check_eq("t6_cnt4_15", xfer_cnt4, 15);
            if (k == 17) check_eq("t6_cnt4_0",  xfer_cnt4, 0);
        end
        check_eq("t6_cnt4_1", xfer_cnt4, 1);
        check_eq("t6_cnt16",  xfer_cnt,  17);
        check_eq("t6_rdlow4", rd_low4,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
